// File: rtl/stream_pkg.sv
// Shared types and width helpers for the stream blocks (arbiter, shift_stream).
package stream_pkg;

    // Arbiter FSM: waiting for a request, or serving one requester's burst.
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Bus width in bytes -> bus width in bits.
    function automatic int unsigned full_data_width(input int unsigned bus_bytes);
        return 8 * bus_bytes;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: lowest requesting index strictly after i_last, wrapping.
module rr_pick #(
    parameter int unsigned N_REQ = 3,
    localparam int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_index
);

    // Scan from lowest to highest priority so the highest-priority hit is written last.
    always_comb begin
        logic [IDX_W-1:0] w_cand;
        o_valid = |i_req;
        o_index = '0;
        w_cand  = '0;
        for (int unsigned i = N_REQ; i >= 1; i--) begin
            w_cand = IDX_W'((32'(i_last) + i) % N_REQ);
            if (i_req[w_cand]) begin
                o_index = w_cand;
            end
        end
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin burst arbiter merging N_REQ valid/ready streams into one registered output.
module stream_rr_arbiter
    import stream_pkg::*;
#(
    parameter int unsigned N_REQ          = 3,
    parameter int unsigned DATA_BUS_WIDTH = 4,
    parameter int unsigned MAX_BURST      = 4,
    localparam int unsigned FULL_DATA_WIDTH = full_data_width(DATA_BUS_WIDTH),
    localparam int unsigned ID_W            = $clog2(N_REQ)
) (
    input  logic                             clk_i,
    input  logic                             areset_ni,
    input  logic [N_REQ-1:0]                 tvalid_i,
    output logic [N_REQ-1:0]                 tready_o,
    input  logic [N_REQ*FULL_DATA_WIDTH-1:0] tdata_i,
    output logic                             tvalid_o,
    input  logic                             tready_i,
    output logic [FULL_DATA_WIDTH-1:0]       tdata_o,
    output logic [ID_W-1:0]                  tid_o
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t                 r_state, w_state_nxt;
    logic [ID_W-1:0]            r_grant, w_grant_nxt;
    logic [ID_W-1:0]            r_last_grant, w_last_grant_nxt;
    logic [CNT_W-1:0]           r_count, w_count_nxt;
    logic                       r_tvalid_o;
    logic [FULL_DATA_WIDTH-1:0] r_tdata_o;
    logic [ID_W-1:0]            r_tid_o;

    logic                       w_pick_valid;
    logic [ID_W-1:0]            w_pick_idx;
    logic                       w_out_free;
    logic                       w_accept;
    logic                       w_last_beat;
    logic [FULL_DATA_WIDTH-1:0] w_slices [N_REQ];

    for (genvar k = 0; k < N_REQ; k++) begin : g_slice
        assign w_slices[k] = tdata_i[k*FULL_DATA_WIDTH +: FULL_DATA_WIDTH];
    end

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .i_req   (tvalid_i),
        .i_last  (r_last_grant),
        .o_valid (w_pick_valid),
        .o_index (w_pick_idx)
    );

    // Output slot can take a beat when empty or being emptied this cycle.
    assign w_out_free  = !r_tvalid_o || tready_i;
    assign w_accept    = (r_state == GRANT) && tvalid_i[r_grant] && w_out_free;
    assign w_last_beat = (r_count == CNT_W'(MAX_BURST - 1));

    // Only the granted requester ever sees ready.
    always_comb begin
        tready_o = '0;
        if (r_state == GRANT) begin
            tready_o[r_grant] = w_out_free;
        end
    end

    // Next-state logic: pick a requester in IDLE, count beats and end bursts in GRANT.
    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_last_grant_nxt = r_last_grant;
        w_count_nxt      = r_count;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = GRANT;
                    w_grant_nxt = w_pick_idx;
                    w_count_nxt = '0;
                end
            end
            GRANT: begin
                if (w_accept) begin
                    w_count_nxt = r_count + CNT_W'(1);
                end
                if ((w_accept && w_last_beat) || !tvalid_i[r_grant]) begin
                    w_state_nxt      = IDLE;
                    w_last_grant_nxt = r_grant;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM, grant and burst-count registers.
    always_ff @(posedge clk_i or negedge areset_ni) begin
        if (!areset_ni) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_last_grant <= ID_W'(N_REQ - 1);
            r_count      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_count      <= w_count_nxt;
        end
    end

    // Output register: load on accept, otherwise drain on downstream handshake.
    always_ff @(posedge clk_i or negedge areset_ni) begin
        if (!areset_ni) begin
            r_tvalid_o <= 1'b0;
            r_tdata_o  <= '0;
            r_tid_o    <= '0;
        end else if (w_accept) begin
            r_tvalid_o <= 1'b1;
            r_tdata_o  <= w_slices[r_grant];
            r_tid_o    <= r_grant;
        end else if (r_tvalid_o && tready_i) begin
            r_tvalid_o <= 1'b0;
        end
    end

    assign tvalid_o = r_tvalid_o;
    assign tdata_o  = r_tdata_o;
    assign tid_o    = r_tid_o;

endmodule
